// File: rtl/reg32_serial_reader_pkg.sv
// Shared definitions for the register serial reader: default word width,
// bits_left counter width and the controller state encoding.
package reg32_serial_reader_pkg;

  // Default word width and the counter width that can still represent it.
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned CNT_W         = 6;

  // Controller states; 2-bit binary encoding is externally visible in benches.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // True while a word is being presented on the bit stream.
  function automatic logic is_active(input rd_state_e st);
    return (st == ST_SHIFT) || (st == ST_LAST);
  endfunction

endpackage

// File: rtl/reg32_serial_reader_shreg_piso.sv
// shreg_piso: WIDTH-bit parallel-in / serial-out shift register.
// Ports:
//   clk       rising-edge clock
//   clr       synchronous clear (highest priority)
//   load      load par_in into the register
//   shift_en  shift one place toward the output end, zero fill
//   par_in    parallel load word
//   ser_out   bit at the output end (MSB if MSB_FIRST, else LSB)
module shreg_piso #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted_c;

  // Direction-dependent shift and output tap.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
      assign ser_out   = shreg_q[WIDTH-1];
    end else begin : g_lsb
      assign shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
      assign ser_out   = shreg_q[0];
    end
  endgenerate

  // Next-value select: clear > load > shift > hold.
  always_comb begin
    shreg_d = shreg_q;
    if (clr) begin
      shreg_d = '0;
    end else if (load) begin
      shreg_d = par_in;
    end else if (shift_en) begin
      shreg_d = shifted_c;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/reg32_serial_reader.sv
// reg32_serial_reader: captures a parallel register word on start and
// emits it one bit per accepted valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      capture data_in and begin a transfer (honoured in IDLE only)
//   data_in    parallel word
//   busy       transfer in progress
//   bit_out    current serial bit, valid when bit_valid=1
//   bit_valid  bit_out holds a valid bit
//   bit_ready  consumer accepts bit_out this cycle
//   done       one-cycle pulse after the final bit is accepted
//   bits_left  bits not yet accepted in the current transfer
module reg32_serial_reader
  import reg32_serial_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             done,
  output logic [CNT_W-1:0] bits_left
);

  // A one-bit word has no SHIFT->LAST path, and bits_left caps at 32.
  generate
    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
      $error("reg32_serial_reader: WIDTH must be in 2..32");
    end
  endgenerate

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             xfer_c;
  logic             load_c;
  logic             shift_c;

  assign xfer_c = valid_q & bit_ready;

  // Next-state, counter and shift-register control.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_c      = 1'b1;
          bits_left_d = CNT_W'(WIDTH);
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer_c) begin
          shift_c = 1'b1;
          if (bits_left_q != '0) begin
            bits_left_d = bits_left_q - CNT_W'(1);
          end
          // Two left before this transfer means only the final bit remains.
          if (bits_left_q == CNT_W'(2)) begin
            state_d = ST_LAST;
          end
        end
      end
      ST_LAST: begin
        if (xfer_c) begin
          shift_c     = 1'b1;
          bits_left_d = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        bits_left_d = '0;
      end
    endcase
  end

  // Status outputs are registered off the next state so they align with it.
  always_comb begin
    busy_d  = is_active(state_d);
    valid_d = is_active(state_d);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  shreg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .clr      (reset),
    .load     (load_c & ~reset),
    .shift_en (shift_c & ~reset),
    .par_in   (data_in),
    .ser_out  (bit_out)
  );

  assign busy      = busy_q;
  assign bit_valid = valid_q;
  assign done      = done_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_reg32_serial_reader.sv
module tb_reg32_serial_reader;
  import reg32_serial_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, bit_ready;
  logic [31:0] data_in;
  logic        busy_m, bit_out_m, bit_valid_m, done_m;
  logic        busy_l, bit_out_l, bit_valid_l, done_l;
  logic [5:0]  bits_left_m, bits_left_l;
  logic        start2, ready2;
  logic [1:0]  data2;
  logic        busy_2, bit_out_2, bit_valid_2, done_2;
  logic [5:0]  bits_left_2;

  int errors = 0;
  int checks = 0;

  // Reference model state for the two 32-bit instances (shared inputs).
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  logic [31:0] m_word   = '0;
  int          m_sent   = 0;

  always #5 clk = ~clk;

  reg32_serial_reader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy_m), .bit_out(bit_out_m), .bit_valid(bit_valid_m),
    .bit_ready(bit_ready), .done(done_m), .bits_left(bits_left_m));

  reg32_serial_reader #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy_l), .bit_out(bit_out_l), .bit_valid(bit_valid_l),
    .bit_ready(bit_ready), .done(done_l), .bits_left(bits_left_l));

  reg32_serial_reader #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_w2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(data2),
    .busy(busy_2), .bit_out(bit_out_2), .bit_valid(bit_valid_2),
    .bit_ready(ready2), .done(done_2), .bits_left(bits_left_2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level behaviour: a captured word is drained bit index by bit index.
  task automatic model_step();
    if (reset) begin
      m_active = 1'b0; m_done = 1'b0; m_sent = 0; m_word = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (bit_ready) begin
        m_sent++;
        if (m_sent == 32) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (start) begin
      m_active = 1'b1; m_word = data_in; m_sent = 0;
    end
  endtask

  task automatic check_model();
    chk("busy_m", 32'(busy_m), 32'(m_active));
    chk("busy_l", 32'(busy_l), 32'(m_active));
    chk("valid_m", 32'(bit_valid_m), 32'(m_active));
    chk("valid_l", 32'(bit_valid_l), 32'(m_active));
    chk("done_m", 32'(done_m), 32'(m_done));
    chk("done_l", 32'(done_l), 32'(m_done));
    chk("bits_left_m", 32'(bits_left_m), m_active ? 32'(32 - m_sent) : 32'd0);
    chk("bits_left_l", 32'(bits_left_l), m_active ? 32'(32 - m_sent) : 32'd0);
    if (m_active) begin
      chk("bit_out_m", 32'(bit_out_m), 32'(m_word[31 - m_sent]));
      chk("bit_out_l", 32'(bit_out_l), 32'(m_word[m_sent]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Drain one transfer that was just started; cycle 1 is the cycle after the start edge.
  task automatic collect(input bit rand_ready, input int pulse_at,
                         output logic [31:0] got_m, output logic [31:0] got_l,
                         output int n, output int done_cyc);
    int   cyc = 1;
    bit   stalled = 1'b0;
    logic held = 1'b0;
    got_m = '0; got_l = '0; n = 0; done_cyc = -1;
    while (cyc <= 300) begin
      if (done_m) begin
        done_cyc = cyc;
        break;
      end
      if (stalled) chk("stall_hold_l", 32'(bit_out_l), 32'(held));
      bit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse_at >= 0) begin
        start = (n == pulse_at);
        if (start) data_in = 32'hFFFF_FFFF;
      end
      if (bit_valid_l && bit_ready && n < 32) got_l[n] = bit_out_l;
      if (bit_valid_m && bit_ready) begin
        got_m = {got_m[30:0], bit_out_m};
        n++;
      end
      stalled = bit_valid_l && !bit_ready;
      held    = bit_out_l;
      tick();
      cyc++;
    end
    if (done_cyc < 0) chk("done_seen", 32'(done_m), 32'd1);
    bit_ready = 1'b1;
    if (pulse_at >= 0) start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic        exp_first_m;
    logic        exp_first_l;
    int          exp_done_cyc;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] gm, gl;
    int          n, dc;

    vecs[0] = '{32'hDEAD_BEEF, 1'b1, 1'b1, 33};
    vecs[1] = '{32'h0000_0001, 1'b0, 1'b1, 33};
    vecs[2] = '{32'h8000_0000, 1'b1, 1'b0, 33};
    vecs[3] = '{32'hA5A5_0F0F, 1'b1, 1'b1, 33};
    vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 33};

    reset = 1'b1; start = 1'b0; data_in = '0; bit_ready = 1'b0;
    start2 = 1'b0; data2 = '0; ready2 = 1'b0;
    tick(); tick();
    chk("rst_bit_out_m", 32'(bit_out_m), 32'd0);
    chk("rst_bits_left_2", 32'(bits_left_2), 32'd0);
    chk("rst_busy_2", 32'(busy_2), 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a transfer: abort with no done pulse.
    start = 1'b1; data_in = 32'hA5A5_0F0F; bit_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_valid", 32'(bit_valid_m), 32'd0);
    chk("abort_bits_left", 32'(bits_left_m), 32'd0);
    chk("abort_bit_out", 32'(bit_out_m), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done_m), 32'd0);
    end

    // Table of full-speed transfers in both bit orders.
    foreach (vecs[i]) begin
      start = 1'b1; data_in = vecs[i].word;
      tick();
      start = 1'b0; data_in = $urandom;
      chk("tbl_first_m", 32'(bit_out_m), 32'(vecs[i].exp_first_m));
      chk("tbl_first_l", 32'(bit_out_l), 32'(vecs[i].exp_first_l));
      collect(1'b0, -1, gm, gl, n, dc);
      chk("tbl_word_m", gm, vecs[i].word);
      chk("tbl_word_l", gl, vecs[i].word);
      chk("tbl_nbits", 32'(n), 32'd32);
      chk("tbl_done_cyc", 32'(dc), 32'(vecs[i].exp_done_cyc));
      tick();
    end

    // A start pulse while busy must neither restart nor queue.
    start = 1'b1; data_in = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    collect(1'b0, 5, gm, gl, n, dc);
    chk("ign_word_m", gm, 32'hDEAD_BEEF);
    chk("ign_word_l", gl, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign_no_restart", 32'(busy_m), 32'd0);
    end

    // Start held high: the second capture lands in the IDLE cycle after DONE.
    start = 1'b1; data_in = 32'h1234_5678;
    tick();
    data_in = 32'h9ABC_DEF0;
    collect(1'b0, -1, gm, gl, n, dc);
    chk("hold_word1", gm, 32'h1234_5678);
    chk("hold_done_cyc", 32'(dc), 32'd33);
    tick();
    chk("hold_idle_gap", 32'(busy_m), 32'd0);
    tick();
    start = 1'b0;
    chk("hold_restart_cyc35", 32'(bit_valid_m), 32'd1);
    chk("hold_restart_cnt", 32'(bits_left_m), 32'd32);
    collect(1'b0, -1, gm, gl, n, dc);
    chk("hold_word2", gm, 32'h9ABC_DEF0);
    tick();

    // LSB-first with random consumer stalls.
    start = 1'b1; data_in = 32'h0000_0001;
    tick();
    start = 1'b0;
    collect(1'b1, -1, gm, gl, n, dc);
    chk("stall_word_l", gl, 32'h0000_0001);
    chk("stall_nbits", 32'(n), 32'd32);
    tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      data_in   = $urandom;
      bit_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b1; start = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Narrow width: SHIFT -> LAST -> DONE.
    start2 = 1'b1; data2 = 2'b10; ready2 = 1'b1;
    tick();
    start2 = 1'b0; data2 = 2'b01;
    chk("w2_busy", 32'(busy_2), 32'd1);
    chk("w2_bit1", 32'(bit_out_2), 32'd1);
    chk("w2_left2", 32'(bits_left_2), 32'd2);
    tick();
    chk("w2_bit0", 32'(bit_out_2), 32'd0);
    chk("w2_left1", 32'(bits_left_2), 32'd1);
    chk("w2_valid_last", 32'(bit_valid_2), 32'd1);
    chk("w2_no_early_done", 32'(done_2), 32'd0);
    tick();
    chk("w2_done", 32'(done_2), 32'd1);
    chk("w2_busy_fall", 32'(busy_2), 32'd0);
    chk("w2_valid_fall", 32'(bit_valid_2), 32'd0);
    chk("w2_left0", 32'(bits_left_2), 32'd0);
    tick();
    chk("w2_done_pulse", 32'(done_2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
